key_expansion_seq: RTL and testbench

//   Sequential, parametrised AES key-expansion engine supporting 128, 192 and 256-bit keys.

---
 rtl/key_expansion_seq.sv | 159 +++++++++++++++
 tb/tb_key_expansion_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_seq.sv
// Sequential AES key expansion for 128/192/256-bit keys: one schedule word per clock,
// full schedule held in a register file and read back one round key at a time.
module key_expansion_seq #(
  parameter int unsigned MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            key_len,
  input  logic [32*MAX_NK-1:0]  key_in,
  output logic                  busy,
  output logic                  keys_valid,
  output logic                  err,
  input  logic [3:0]            rd_round,
  output logic [127:0]          rd_key
);

  localparam int unsigned KW    = 32 * MAX_NK;
  localparam int unsigned DEPTH = 4 * (MAX_NK + 7);
  localparam int unsigned AW    = $clog2(DEPTH);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t         state, state_d;
  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  idx;
  logic [2:0]     phase;
  logic [7:0]     rcon;
  logic [1:0]     mode;

  logic [3:0]     nk_in, nk_q, nr_q;
  logic           legal, accept, reject, last;
  logic [AW-1:0]  last_idx, base;
  logic [31:0]    prev, old, sub_in, sub_out, temp, new_w;
  logic [127:0]   rd_data;

  function automatic logic [3:0] nk_of(input logic [1:0] m);
    case (m)
      2'b00:   return 4'd4;
      2'b01:   return 4'd6;
      2'b10:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[{~a, 3'b000} +: 8];
  endfunction

  // Start qualification and mode decode
  always_comb begin
    nk_in    = nk_of(key_len);
    nk_q     = nk_of(mode);
    nr_q     = nk_q + 4'd6;
    legal    = (key_len != 2'b11) && (32'(nk_in) <= MAX_NK);
    accept   = (state == IDLE) && start && legal;
    reject   = (state == IDLE) && start && !legal;
    last_idx = AW'({nk_q, 2'b00}) + AW'(27);
    last     = (state == EXPAND) && (idx == last_idx);
  end

  // Next schedule word: w[i] = w[i-Nk] ^ f(w[i-1]); phase tracks i mod Nk
  always_comb begin
    prev   = mem[idx - AW'(1)];
    old    = mem[idx - AW'(nk_q)];
    sub_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    for (int b = 0; b < 4; b++) begin
      sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
    end
    if (phase == 3'd0) begin
      temp = sub_out ^ {rcon, 24'h0};
    end else if (nk_q == 4'd8 && phase == 3'd4) begin
      temp = sub_out;
    end else begin
      temp = prev;
    end
    new_w = old ^ temp;
  end

  always_comb begin
    rd_data = '0;
    base    = AW'({rd_round, 2'b00});
    if (rd_round <= nr_q) begin
      rd_data = {mem[base], mem[base + AW'(1)], mem[base + AW'(2)], mem[base + AW'(3)]};
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = EXPAND;
      EXPAND:  if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      err        <= 1'b0;
      rd_key     <= '0;
      idx        <= '0;
      phase      <= '0;
      rcon       <= '0;
      mode       <= '0;
    end else begin
      state  <= state_d;
      err    <= reject;
      rd_key <= rd_data;
      if (accept) begin
        busy       <= 1'b1;
        keys_valid <= 1'b0;
        mode       <= key_len;
        idx        <= AW'(nk_in);
        phase      <= '0;
        rcon       <= 8'h01;
      end else if (state == EXPAND) begin
        idx   <= idx + AW'(1);
        phase <= (phase == 3'(nk_q - 4'd1)) ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) begin
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
        if (last) begin
          busy       <= 1'b0;
          keys_valid <= 1'b1;
        end
      end
    end
  end

  // Schedule storage has no reset; validity is tracked by keys_valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int unsigned j = 0; j < MAX_NK; j++) begin
          if (j < 32'(nk_in)) begin
            mem[AW'(j)] <= key_in[KW-1-32*j -: 32];
          end
        end
      end else if (state == EXPAND) begin
        mem[idx] <= new_w;
      end
    end
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq: stimulus pushes expected values tagged with
// the cycle they are due; a negedge monitor pops and compares against the DUT.
module tb_key_expansion_seq;

  logic         clk = 1'b0;
  logic         rst, start, busy, keys_valid, err;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  key_expansion_seq #(.MAX_NK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
    .busy(busy), .keys_valid(keys_valid), .err(err), .rd_round(rd_round), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  typedef struct {
    int           cyc;
    int           sel;
    string        name;
    logic [127:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int busy_len = 0;
  int n;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle
  sb_item_t     it;
  logic [127:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      total_cnt++;
      case (it.sel)
        0:       act = rd_key;
        1:       act = 128'(busy);
        2:       act = 128'(keys_valid);
        3:       act = 128'(err);
        default: act = 128'(busy_len);
      endcase
      if (it.cyc != cyc)
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", it.name, it.cyc, cyc);
      else if (act !== it.exp)
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      else
        pass_cnt++;
    end
  end

  task automatic exp_push(input int sel, input string name, input logic [127:0] e);
    sb_item_t x;
    x.cyc  = cyc + 1;
    x.sel  = sel;
    x.name = name;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [3:0] r, input string name, input logic [127:0] e);
    rd_round = r;
    exp_push(0, name, e);
    tick();
  endtask

  // Launch one expansion; optionally pulse a second start mid-run or stop early
  task automatic run(input logic [1:0] kl, input logic [255:0] k, input int glitch_at,
                     input int abort_at, output int cnt);
    key_len = kl;
    key_in  = k;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    key_in  = '0;
    key_len = 2'b11;
    cnt     = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (cnt == abort_at) break;
      if (cnt == 1) exp_push(2, "kv_low_while_busy", 0);
      if (cnt == glitch_at) begin
        start   = 1'b1;
        key_len = 2'b00;
        key_in  = ~k;
        exp_push(3, "start_while_busy_err", 0);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_len = 2'b00; key_in = '0; rd_round = '0;
    tick();
    exp_push(1, "rst_busy", 0);
    exp_push(2, "rst_kv", 0);
    exp_push(3, "rst_err", 0);
    exp_push(0, "rst_rd_key", 0);
    tick();
    rst = 1'b0;

    // 128-bit with an ignored second start during expansion
    run(2'b00, {K128, 128'h0}, 5, 0, n);
    busy_len = n;
    exp_push(4, "len128", 40);
    exp_push(2, "kv128", 1);
    tick();
    read_chk(4'd0,  "r128_0",  K128);
    read_chk(4'd1,  "r128_1",  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    read_chk(4'd2,  "r128_2",  128'hf2c295f2_7a96b943_5935807a_7359f67f);
    read_chk(4'd10, "r128_10", 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    read_chk(4'd11, "r128_11", 128'h0);

    // Illegal key length
    start = 1'b1; key_len = 2'b11;
    exp_push(3, "ill_err", 1);
    exp_push(1, "ill_busy", 0);
    tick();
    start = 1'b0;
    exp_push(3, "ill_err_pulse", 0);
    exp_push(2, "ill_kv_kept", 1);
    exp_push(1, "ill_busy_after", 0);
    tick();
    read_chk(4'd10, "r128_10_after_ill", 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    // 192-bit
    run(2'b01, {K192, 64'h0}, 0, 0, n);
    busy_len = n;
    exp_push(4, "len192", 46);
    exp_push(2, "kv192", 1);
    tick();
    read_chk(4'd1,  "r192_1",  128'h62f8ead2_522c6b7b_fe0c91f7_2402f5a5);
    read_chk(4'd12, "r192_12", 128'he98ba06f_448c773c_8ecc7204_01002202);
    read_chk(4'd13, "r192_13", 128'h0);

    // 256-bit, then a 192-bit run launched the cycle after it completes
    run(2'b10, K256, 0, 0, n);
    busy_len = n;
    exp_push(4, "len256", 52);
    exp_push(2, "kv256", 1);
    tick();
    read_chk(4'd0,  "r256_0",  K256[255:128]);
    read_chk(4'd1,  "r256_1",  K256[127:0]);
    read_chk(4'd2,  "r256_2",  128'h9ba35411_8e6925af_a51a8b5f_2067fcde);
    read_chk(4'd14, "r256_14", 128'hfe4890d1_e6188d0b_046df344_706c631e);
    read_chk(4'd15, "r256_15", 128'h0);
    run(2'b01, {K192, 64'h0}, 0, 0, n);
    run(2'b10, K256, 0, 0, n);
    busy_len = n;
    exp_push(4, "len256_b2b", 52);
    tick();
    read_chk(4'd14, "r256_14_b2b", 128'hfe4890d1_e6188d0b_046df344_706c631e);
    run(2'b01, {K192, 64'h0}, 0, 0, n);
    read_chk(4'd12, "r192_12_b2b", 128'he98ba06f_448c773c_8ecc7204_01002202);
    read_chk(4'd14, "r192_14_b2b", 128'h0);

    // Reset 20 cycles into a 128-bit run, then a fresh run
    run(2'b00, {K128, 128'h0}, 0, 20, n);
    rst = 1'b1;
    rd_round = 4'd10;
    exp_push(1, "abort_busy", 0);
    exp_push(2, "abort_kv", 0);
    exp_push(0, "abort_rd_key", 0);
    tick();
    rst = 1'b0;
    exp_push(2, "abort_kv_hold", 0);
    exp_push(1, "abort_busy_hold", 0);
    tick();
    run(2'b00, {K128, 128'h0}, 0, 0, n);
    busy_len = n;
    exp_push(4, "len128_rerun", 40);
    exp_push(2, "kv128_rerun", 1);
    tick();
    read_chk(4'd10, "r128_10_rerun", 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    read_chk(4'd11, "r128_11_rerun", 128'h0);

    tick(); tick(); tick();
    while (sb.size() > 0) begin
      it = sb.pop_front();
      total_cnt++;
      $display("FAIL %s: never compared, expected %h", it.name, it.exp);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
